// File: rtl/lcd_spi_deserializer.sv
// LCD SPI deserializer: receives 8-bit command / 16-bit pixel words
// from a 4-wire LCD serial bus and offers them on a 1-deep output register.
//
// Ports:
//   clk, rst_n       system clock, synchronous active-low reset
//   lcd_sclk         serial clock, data sampled on its rising edge
//   lcd_data         serial data, MSB first
//   lcd_dc           0 = 8-bit command word, 1 = 16-bit pixel word
//   lcd_cs_n         active-low frame select
//   out_valid/ready  output handshake
//   out_data         received word (commands zero-extended)
//   out_is_cmd       out_data holds a command word
//   overflow         sticky: completed word dropped
//   frame_err        sticky: partial word aborted by lcd_cs_n
//   clr_flags        pulse clears overflow and frame_err
//   rx_busy          bit count is nonzero

module lcd_spi_deserializer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lcd_sclk,
    input  logic        lcd_data,
    input  logic        lcd_dc,
    input  logic        lcd_cs_n,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_is_cmd,
    output logic        overflow,
    output logic        frame_err,
    input  logic        clr_flags,
    output logic        rx_busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Synchronizer word: {valid, sclk, data, dc, cs_n}.
    // The valid bit travels with the samples so the edge detector
    // can tell real samples from reset fill after rst_n releases.
    logic [4:0]  sync_q [SYNC_STAGES];
    logic [4:0]  sync_d [SYNC_STAGES];

    logic        s_vld;
    logic        s_sclk;
    logic        s_data;
    logic        s_dc;
    logic        s_cs_n;

    logic        sclk_prev_q;
    logic        sclk_prev_d;
    logic        rise;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    logic [15:0] sh_q;
    logic [15:0] sh_d;
    logic        is16_q;
    logic        is16_d;
    logic [3:0]  last_bit;

    logic        done;
    logic        frm_set;
    logic [15:0] word;

    logic        valid_q;
    logic        valid_d;
    logic [15:0] data_q;
    logic [15:0] data_d;
    logic        cmd_q;
    logic        cmd_d;
    logic        ovf_q;
    logic        ovf_d;
    logic        frm_q;
    logic        frm_d;
    logic        ovf_set;

    assign {s_vld, s_sclk, s_data, s_dc, s_cs_n} =
        sync_q[SYNC_STAGES-1];

    // Until real samples emerge, pretend sclk was already high so a
    // line sitting at 1 across reset release is not taken as an edge.
    assign sclk_prev_d = s_sclk | ~s_vld;
    assign rise        = s_sclk & ~sclk_prev_q;

    always_comb begin
        sync_d[0] = {1'b1, lcd_sclk, lcd_data, lcd_dc, lcd_cs_n};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign last_bit = is16_q ? 4'd15 : 4'd7;

    // State register and all other flops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            sclk_prev_q <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            is16_q      <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            cmd_q       <= 1'b0;
            ovf_q       <= 1'b0;
            frm_q       <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            sclk_prev_q <= sclk_prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            is16_q      <= is16_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            cmd_q       <= cmd_d;
            ovf_q       <= ovf_d;
            frm_q       <= frm_d;
        end
    end

    // Next-state: receiver shift / count / abort
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        is16_d  = is16_q;
        done    = 1'b0;
        frm_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise && !s_cs_n) begin
                    is16_d  = s_dc;
                    // Start from a clean register: no stale bits.
                    sh_d    = {15'd0, s_data};
                    cnt_d   = 4'd1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (s_cs_n) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    frm_set = 1'b1;
                end else if (rise) begin
                    sh_d = {sh_q[14:0], s_data};
                    if (cnt_q == last_bit) begin
                        done    = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
        endcase
    end

    assign word = is16_q ? sh_d : {8'h00, sh_d[7:0]};

    // Outputs: 1-deep output register and sticky flags
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        cmd_d   = cmd_q;
        ovf_set = 1'b0;
        if (done) begin
            // A word arriving on the accept cycle replaces the held one.
            if (!valid_q || out_ready) begin
                valid_d = 1'b1;
                data_d  = word;
                cmd_d   = ~is16_q;
            end else begin
                ovf_set = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        ovf_d = ovf_set | (ovf_q & ~clr_flags);
        frm_d = frm_set | (frm_q & ~clr_flags);
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign out_is_cmd = cmd_q;
    assign overflow   = ovf_q;
    assign frame_err  = frm_q;
    assign rx_busy    = (cnt_q != 4'd0);

endmodule

// File: tb/tb_lcd_spi_deserializer.sv
// Testbench for lcd_spi_deserializer: vector table, directed corner
// sequences and randomized words against a word-level reference queue.

module tb_lcd_spi_deserializer;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lcd_sclk;
    logic        lcd_data;
    logic        lcd_dc;
    logic        lcd_cs_n;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_is_cmd;
    logic        overflow;
    logic        frame_err;
    logic        clr_flags;
    logic        rx_busy;

    int errors = 0;
    int checks = 0;
    bit rand_rdy = 1'b0;

    logic [16:0] got_q[$];
    logic [16:0] exp_q[$];

    typedef struct {
        logic        dc;
        logic [15:0] word;
        logic [15:0] exp_data;
        logic        exp_cmd;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    lcd_spi_deserializer #(.SYNC_STAGES(SYNC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lcd_sclk  (lcd_sclk),
        .lcd_data  (lcd_data),
        .lcd_dc    (lcd_dc),
        .lcd_cs_n  (lcd_cs_n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_is_cmd(out_is_cmd),
        .overflow  (overflow),
        .frame_err (frame_err),
        .clr_flags (clr_flags),
        .rx_busy   (rx_busy)
    );

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready)
            got_q.push_back({out_is_cmd, out_data});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_bit(input logic b, input int h);
        lcd_data = b;
        lcd_sclk = 1'b0;
        repeat (h) tick();
        lcd_sclk = 1'b1;
        repeat (h) tick();
    endtask

    task automatic send_word(input logic dc, input logic [15:0] w,
                             input int nbits, input int h,
                             input int flip_at);
        int width;
        width = dc ? 16 : 8;
        lcd_dc   = dc;
        lcd_cs_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (i == flip_at) lcd_dc = ~lcd_dc;
            send_bit(w[width-1-i], h);
        end
    endtask

    task automatic settle();
        repeat (SYNC + 3) tick();
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (out_valid && n < 200) begin
            tick();
            n++;
        end
        check(name, {31'd0, out_valid}, 32'd0);
    endtask

    task automatic cmp_queue(input string name);
        check({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check(name, {15'd0, got_q[i]}, {15'd0, exp_q[i]});
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic pulse_clr();
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        tick();
    endtask

    initial begin
        vecs[0] = '{1'b0, 16'h00A5, 16'h00A5, 1'b1};
        vecs[1] = '{1'b1, 16'hF81F, 16'hF81F, 1'b0};
        vecs[2] = '{1'b0, 16'hAB3C, 16'h003C, 1'b1};
        vecs[3] = '{1'b1, 16'h0000, 16'h0000, 1'b0};
        vecs[4] = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b0};
        vecs[5] = '{1'b0, 16'h00FF, 16'h00FF, 1'b1};
        vecs[6] = '{1'b0, 16'h0000, 16'h0000, 1'b1};
        vecs[7] = '{1'b1, 16'h8001, 16'h8001, 1'b0};

        rst_n     = 1'b0;
        lcd_sclk  = 1'b1;
        lcd_data  = 1'b0;
        lcd_dc    = 1'b0;
        lcd_cs_n  = 1'b0;
        out_ready = 1'b1;
        clr_flags = 1'b0;
        repeat (3) tick();

        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {16'd0, out_data}, 32'd0);
        check("rst_cmd", {31'd0, out_is_cmd}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_frm", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, rx_busy}, 32'd0);

        // sclk held high across release must not count as an edge
        rst_n = 1'b1;
        repeat (6) tick();
        check("release_busy", {31'd0, rx_busy}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            send_word(vecs[i].dc, vecs[i].word,
                      vecs[i].dc ? 16 : 8, 1 + (i % 2), -1);
            settle();
            drain("vec_drain");
            exp_q.push_back({vecs[i].exp_cmd, vecs[i].exp_data});
            cmp_queue("vec");
        end
        check("vec_ovf", {31'd0, overflow}, 32'd0);
        check("vec_frm", {31'd0, frame_err}, 32'd0);

        // Latency: out_valid one cycle after the 8th detected edge
        send_word(1'b0, 16'h00A5, 7, 2, -1);
        lcd_data = 1'b1;
        lcd_sclk = 1'b0;
        repeat (2) tick();
        lcd_sclk = 1'b1;
        repeat (SYNC) tick();
        check("lat_early", {31'd0, out_valid}, 32'd0);
        tick();
        check("lat_valid", {31'd0, out_valid}, 32'd1);
        check("lat_data", {16'd0, out_data}, 32'h00A5);
        check("lat_cmd", {31'd0, out_is_cmd}, 32'd1);
        tick();
        check("lat_pulse", {31'd0, out_valid}, 32'd0);
        exp_q.push_back({1'b1, 16'h00A5});
        cmp_queue("lat");

        // Back-to-back pixel words, sclk toggling every clk
        send_word(1'b1, 16'hF81F, 16, 1, -1);
        send_word(1'b1, 16'h07E0, 16, 1, -1);
        settle();
        drain("b2b_drain");
        exp_q.push_back({1'b0, 16'hF81F});
        exp_q.push_back({1'b0, 16'h07E0});
        cmp_queue("b2b");
        check("b2b_ovf", {31'd0, overflow}, 32'd0);
        check("b2b_frm", {31'd0, frame_err}, 32'd0);

        // Overflow: second command dropped while first held
        out_ready = 1'b0;
        send_word(1'b0, 16'h002A, 8, 1, -1);
        settle();
        send_word(1'b0, 16'h002B, 8, 1, -1);
        settle();
        check("ovf_valid", {31'd0, out_valid}, 32'd1);
        check("ovf_held", {16'd0, out_data}, 32'h002A);
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        out_ready = 1'b1;
        tick();
        check("ovf_accept", {31'd0, out_valid}, 32'd0);
        exp_q.push_back({1'b1, 16'h002A});
        cmp_queue("ovf");
        pulse_clr();
        check("ovf_clr", {31'd0, overflow}, 32'd0);

        // Frame abort after 9 bits, then a full word
        send_word(1'b1, 16'hA5A5, 9, 1, -1);
        check("frm_busy", {31'd0, rx_busy}, 32'd1);
        lcd_cs_n = 1'b1;
        repeat (4) tick();
        check("frm_idle", {31'd0, rx_busy}, 32'd0);
        check("frm_set", {31'd0, frame_err}, 32'd1);
        send_word(1'b1, 16'h1234, 16, 1, -1);
        settle();
        drain("frm_drain");
        check("frm_sticky", {31'd0, frame_err}, 32'd1);
        exp_q.push_back({1'b0, 16'h1234});
        cmp_queue("frm");
        pulse_clr();
        check("frm_clr", {31'd0, frame_err}, 32'd0);

        // dc toggled mid-word is ignored
        send_word(1'b1, 16'hBEEF, 16, 2, 3);
        settle();
        drain("dc_drain");
        exp_q.push_back({1'b0, 16'hBEEF});
        cmp_queue("dc");

        // Reset mid-word discards partial bits silently
        send_word(1'b1, 16'hFFFF, 5, 1, -1);
        rst_n = 1'b0;
        repeat (2) tick();
        check("mid_rst_busy", {31'd0, rx_busy}, 32'd0);
        rst_n = 1'b1;
        tick();
        send_word(1'b0, 16'h0011, 8, 1, -1);
        settle();
        drain("mid_rst_drain");
        check("mid_rst_frm", {31'd0, frame_err}, 32'd0);
        exp_q.push_back({1'b1, 16'h0011});
        cmp_queue("mid_rst");

        // Randomized words against a word-level reference queue
        rand_rdy = 1'b1;
        for (int it = 0; it < 60; it++) begin
            logic        dc;
            logic [15:0] w;
            int          h;
            int          width;
            int          mode;
            bit          exp_frm;
            dc      = 1'($urandom_range(0, 1));
            w       = 16'($urandom);
            h       = $urandom_range(1, 2);
            width   = dc ? 16 : 8;
            mode    = $urandom_range(0, 5);
            exp_frm = 1'b0;
            if (mode == 0) begin
                send_word(dc, w, $urandom_range(1, width - 1), h, -1);
                lcd_cs_n = 1'b1;
                repeat ($urandom_range(2, 4)) tick();
                exp_frm = 1'b1;
            end else begin
                send_word(dc, w, width, h,
                          mode == 1 ? $urandom_range(1, width - 1) : -1);
                exp_q.push_back({~dc, dc ? w : {8'h00, w[7:0]}});
                if (mode == 2) begin
                    lcd_cs_n = 1'b1;
                    tick();
                    send_bit(1'($urandom_range(0, 1)), 1);
                    send_bit(1'($urandom_range(0, 1)), 1);
                    tick();
                end
            end
            settle();
            drain("rand_drain");
            check("rand_frm", {31'd0, frame_err}, {31'd0, exp_frm});
            check("rand_ovf", {31'd0, overflow}, 32'd0);
            cmp_queue("rand");
            if (exp_frm) pulse_clr();
        end
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_spi_deserializer.md
LCD_SPI_DESERIALIZER -- requirements
Module: lcd_spi_deserializer

Interface
REQ-001 Parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on each serial input (legal values 1 to 3).
REQ-002 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 lcd_sclk  input  1  serial clock; data SHALL be sampled on its rising edge.
REQ-005 lcd_data  input  1  serial data, MSB first.
REQ-006 lcd_dc  input  1  0 selects an 8-bit command word, 1 selects a 16-bit pixel word.
REQ-007 lcd_cs_n  input  1  active-low frame select; tie to 0 when no chip-select is present.
REQ-008 out_valid  output  1  a received word is held on out_data/out_is_cmd.
REQ-009 out_ready  input  1  the consumer accepts the word when out_valid and out_ready are both 1.
REQ-010 out_data  output  16  received word; command words SHALL be zero-extended in [15:8].
REQ-011 out_is_cmd  output  1  1 when out_data holds an 8-bit command word.
REQ-012 overflow  output  1  sticky flag: a completed word was dropped.
REQ-013 frame_err  output  1  sticky flag: a partial word was aborted by lcd_cs_n.
REQ-014 clr_flags  input  1  a 1-cycle pulse clears overflow and frame_err.
REQ-015 rx_busy  output  1  1 while the bit count is nonzero.

Function
REQ-016 lcd_sclk, lcd_data, lcd_dc and lcd_cs_n SHALL each pass through SYNC_STAGES flops so all four stay aligned.
REQ-017 A rising edge SHALL be detected when the synchronized sclk is 1 and its previous registered value is 0; only one edge is recognised per low-to-high transition.
REQ-018 When the source shares clk, each sclk level lasts at least 1 clk cycle; otherwise each level lasts at least 2 clk cycles, and faster input is unsupported.
REQ-019 Receiver states: IDLE (bit count 0) and SHIFT (bit count 1 to width-1).
REQ-020 IDLE -> SHIFT on a rising edge with synchronized cs_n = 0.
- Latch the synchronized dc as the word type: width 8 if dc = 0, width 16 if dc = 1.
- Shift in bit 1.
REQ-021 In SHIFT, each rising edge SHALL shift the synchronized data into the LSB of a 16-bit shift register and increment the bit count.
REQ-022 The latched word type SHALL hold until the word completes; dc changes mid-word SHALL be ignored.
REQ-023 On the edge that samples bit number "width", the word completes and the bit count returns to 0 (IDLE).
- The word SHALL be offered on out_* at the next clk edge: out_valid rises exactly 1 cycle after the detect cycle.
REQ-024 Back-to-back words with no idle sclk cycles SHALL be received without loss when out_ready is held at 1.
REQ-025 Output register, 1 deep: out_valid, out_data and out_is_cmd SHALL stay stable until the handshake completes; out_valid falls the cycle after acceptance unless a new word loads.
REQ-026 Word completes while out_valid = 1 and out_ready = 0: drop the new word, keep the held word, set overflow.
REQ-027 Word completes in the same cycle that out_ready = 1 with out_valid = 1: load the new word; out_valid stays 1 and overflow is not set.
REQ-028 Synchronized cs_n = 1 while the bit count is nonzero: return the bit count to 0, discard the partial word, set frame_err.
REQ-029 Rising edges while cs_n = 1 SHALL be ignored.
REQ-030 If clr_flags and a set condition occur in the same cycle, the set SHALL win.
REQ-031 The output register SHALL be unaffected by lcd_cs_n.

Reset
REQ-032 While rst_n = 0, at each clk edge:
- out_valid, out_data, out_is_cmd, overflow, frame_err and rx_busy = 0.
- Bit count, shift register and latched type = 0.
- Synchronizer flops and the sclk history flop = 0.
REQ-033 A reset asserted mid-word SHALL discard the partial word without setting frame_err; the first rising edge after release starts a new word.
REQ-034 After reset release, a sclk already at 1 SHALL NOT count as an edge.

Verification
REQ-035 dc = 0, shift 0xA5 with out_ready = 1 -> exactly one out_valid pulse, out_data = 0x00A5, out_is_cmd = 1, 1 cycle after the 8th detected edge.
REQ-036 dc = 1, shift 0xF81F then 0x07E0 back to back, sclk toggling every clk -> two words 0xF81F and 0x07E0, out_is_cmd = 0, no flags set.
REQ-037 out_ready = 0, send commands 0x2A then 0x2B -> 0x2A held, overflow = 1; raise out_ready -> 0x2A accepted; clr_flags -> overflow = 0.
REQ-038 dc = 1, 9 bits then lcd_cs_n = 1 for 4 cycles, then a full 0x1234 word -> frame_err = 1, only 0x1234 delivered.
REQ-039 Toggle dc after bit 3 of a pixel word 0xBEEF -> out_data = 0xBEEF, out_is_cmd = 0.
REQ-040 rst_n = 0 after 5 bits, release, send command 0x11 -> out_data = 0x0011, frame_err = 0, no stale bits.
